// File: rtl/config_stream_loader.sv
// Byte-stream loader for the PE tile configuration bus: assembles (address, data)
// records from a valid/ready byte stream and presents each one for exactly one clock.
module config_stream_loader #(
   parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_written
);

   localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t      state_r;
   logic [1:0]  byte_idx_r;
   logic [23:0] shift_r;
   logic [31:0] addr_r;
   logic [31:0] remaining_r;

   logic        xfer_s;
   logic        last_byte_s;
   logic [31:0] full_word_s;

   // Bytes arrive LSB first, so the newest byte enters at the top of the shift register.
   assign full_word_s = {in_data, shift_r};
   assign xfer_s      = in_valid && in_ready;
   assign last_byte_s = xfer_s && (byte_idx_r == 2'd3);

   // Ready and busy are pure decodes of the registered state.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_r)
         S_COUNT, S_ADDR, S_DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_WRITE: begin
            in_ready = 1'b0;
            busy     = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
            busy     = 1'b0;
         end
      endcase
   end

   // Loader FSM with byte assembly and registered bus/status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= S_IDLE;
         byte_idx_r    <= 2'd0;
         shift_r       <= 24'd0;
         addr_r        <= 32'd0;
         remaining_r   <= 32'd0;
         config_addr   <= IDLE_ADDR;
         config_data   <= 32'd0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= 16'd0;
      end else begin
         if (xfer_s) begin
            shift_r    <= full_word_s[31:8];
            byte_idx_r <= byte_idx_r + 2'd1;
         end else begin
            shift_r    <= shift_r;
            byte_idx_r <= byte_idx_r;
         end

         case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_r       <= S_COUNT;
                  byte_idx_r    <= 2'd0;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  words_written <= 16'd0;
               end else begin
                  state_r <= state_r;
               end
            end
            S_COUNT: begin
               if (last_byte_s) begin
                  if (full_word_s == 32'd0) begin
                     state_r <= S_DONE;
                     done    <= 1'b1;
                  end else if (full_word_s > MAX_COUNT) begin
                     state_r <= S_ERROR;
                     error   <= 1'b1;
                  end else begin
                     remaining_r <= full_word_s;
                     state_r     <= S_ADDR;
                  end
               end else begin
                  state_r <= S_COUNT;
               end
            end
            S_ADDR: begin
               if (last_byte_s) begin
                  addr_r  <= full_word_s;
                  state_r <= S_DATA;
               end else begin
                  state_r <= S_ADDR;
               end
            end
            S_DATA: begin
               if (last_byte_s) begin
                  config_addr <= addr_r;
                  config_data <= full_word_s;
                  state_r     <= S_WRITE;
               end else begin
                  state_r <= S_DATA;
               end
            end
            S_WRITE: begin
               // The tile array latches during this single cycle; the bus returns to idle next.
               config_addr   <= IDLE_ADDR;
               config_data   <= 32'd0;
               words_written <= words_written + 16'd1;
               remaining_r   <= remaining_r - 32'd1;
               if (remaining_r == 32'd1) begin
                  state_r <= S_DONE;
                  done    <= 1'b1;
               end else begin
                  state_r <= S_ADDR;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               config_addr <= IDLE_ADDR;
               config_data <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench for config_stream_loader: vector table of loads plus
// hand-written corner sequences, with a scoreboard of expected config writes.
module tb_config_stream_loader;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic [63:0] exp_q[$];
   int          wr_cyc[$];

   typedef struct {
      logic [31:0] count;
      int          nrec;
      bit          stall;
      logic        exp_done;
      logic        exp_error;
      logic        exp_busy;
      logic        exp_ready;
      logic [15:0] exp_ww;
   } vec_t;

   vec_t vecs[7];

   config_stream_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .config_addr(config_addr),
      .config_data(config_data), .busy(busy), .done(done), .error(error),
      .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: any non-idle bus cycle is a write and must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en && (config_addr !== IDLE || config_data !== 32'h0)) begin
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_write", config_addr, IDLE);
         end else begin
            check("write_addr", config_addr, exp_q[0][63:32]);
            check("write_data", config_data, exp_q[0][31:0]);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stall);
      if (stall) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
      check("ready_wait", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
   endtask

   task automatic send_record(input logic [31:0] a, input logic [31:0] d, input bit stall);
      send_word(a, stall);
      for (int i = 0; i < 3; i++) send_byte(d[8*i +: 8], stall);
      exp_q.push_back({a, d});
      send_byte(d[31:24], stall);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      start    = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{32'd1,          1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[1] = '{32'd3,          3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
      vecs[2] = '{32'd0,          0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[3] = '{32'd1024,       0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
      vecs[4] = '{32'd1025,       0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[5] = '{32'h8000_0000,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
      vecs[6] = '{32'd2,          2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};

      // Reset with in_valid asserted, then idle hold.
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (2) @(negedge clk);
      check("rst_addr",  config_addr, IDLE);
      check("rst_data",  config_data, 32'h0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_ww",    {16'd0, words_written}, 32'd0);
      reset    = 1'b1;
      in_valid = 1'b0;
      mon_en   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_addr_hold", config_addr, IDLE);
         check("idle_busy_hold", {30'd0, busy, done}, 32'd0);
      end

      // Table-driven loads.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         do_start();
         send_word(vecs[v].count, vecs[v].stall);
         for (int j = 0; j < vecs[v].nrec; j++) begin
            send_record({16'd4 + 16'(j % 4), 16'(v * 16 + j)}, $urandom, vecs[v].stall);
         end
         if (vecs[v].nrec > 0) @(negedge clk);
         check("vec_done",    {31'd0, done},     {31'd0, vecs[v].exp_done});
         check("vec_error",   {31'd0, error},    {31'd0, vecs[v].exp_error});
         check("vec_busy",    {31'd0, busy},     {31'd0, vecs[v].exp_busy});
         check("vec_ready",   {31'd0, in_ready}, {31'd0, vecs[v].exp_ready});
         check("vec_ww",      {16'd0, words_written}, {16'd0, vecs[v].exp_ww});
         check("vec_pending", exp_q.size(), 32'd0);
      end

      // Single record from the byte sequence 01 00 00 00, 05 00 07 00, 03 00 00 00.
      do_reset();
      do_start();
      send_word(32'd1, 1'b0);
      send_record(32'h0007_0005, 32'h0000_0003, 1'b0);
      @(negedge clk);
      check("single_addr_idle", config_addr, IDLE);
      check("single_data_zero", config_data, 32'h0);
      check("single_done", {31'd0, done}, 32'd1);
      check("single_ww",   {16'd0, words_written}, 32'd1);
      check("single_busy", {31'd0, busy}, 32'd0);

      // Full-rate throughput: writes 9 cycles apart.
      do_reset();
      wr_cyc.delete();
      do_start();
      send_word(32'd3, 1'b0);
      for (int j = 0; j < 3; j++) send_record({16'd6, 16'(j)}, 32'h1000_0000 + 32'(j), 1'b0);
      @(negedge clk);
      check("tp_writes", wr_cyc.size(), 32'd3);
      if (wr_cyc.size() == 3) begin
         check("tp_gap0", 32'(wr_cyc[1] - wr_cyc[0]), 32'd9);
         check("tp_gap1", 32'(wr_cyc[2] - wr_cyc[1]), 32'd9);
      end
      check("tp_done", {31'd0, done}, 32'd1);

      // Error recovery through start.
      do_reset();
      do_start();
      send_word(32'd1025, 1'b0);
      check("err_set",   {31'd0, error}, 32'd1);
      check("err_ready", {31'd0, in_ready}, 32'd0);
      do_start();
      check("err_clear", {31'd0, error}, 32'd0);
      check("err_ready_after_start", {31'd0, in_ready}, 32'd1);

      // Reset after the 7th byte of a record drops it.
      do_reset();
      do_start();
      send_word(32'd1, 1'b0);
      send_word(32'h0005_0033, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'h11 + 8'(i), 1'b0);
      do_reset();
      repeat (3) @(negedge clk);
      check("midrst_addr", config_addr, IDLE);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      do_start();
      send_word(32'd1, 1'b1);
      send_record(32'h0004_0009, 32'hCAFE_F00D, 1'b1);
      @(negedge clk);
      check("midrst_ww",   {16'd0, words_written}, 32'd1);
      check("midrst_done", {31'd0, done}, 32'd1);

      // start pulsed during ADDR is ignored.
      do_reset();
      do_start();
      send_word(32'd2, 1'b0);
      send_byte(8'h21, 1'b0);
      send_byte(8'h00, 1'b0);
      do_start();
      send_byte(8'h07, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b0);
      exp_q.push_back({32'h0007_0021, 32'h5542_4140});
      send_byte(8'h55, 1'b0);
      send_record(32'h0005_0022, 32'h0BAD_BEEF, 1'b0);
      @(negedge clk);
      check("sb_done",    {31'd0, done}, 32'd1);
      check("sb_ww",      {16'd0, words_written}, 32'd2);
      check("sb_pending", exp_q.size(), 32'd0);

      repeat (5) @(negedge clk);
      check("final_pending", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream feeder of the PE tile array's shared configuration bus.
- Takes a byte stream with a valid/ready handshake from the host or boot ROM and assembles (address, data) records.
- Drives each record onto config_addr/config_data for exactly one clock, so exactly one tile sub-block (SB/CB0/CB1/CLB) latches it.
- Tracks record count and reports done/error status to the host.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFF: value driven on config_addr when no write is in progress. Its upper 16 bits must match no sub-block code (4..7).
- MAX_WORDS, 1024: largest legal record count. A larger header count is an error.

Ports:
- clk  in  1  fabric clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin loading a new bitstream. Sampled only in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- config_addr  out  32  to the tile array. [31:16] is the sub-block code, [15:0] is the tile_id.
- config_data  out  32  to the tile array.
- busy  out  1  high in COUNT, ADDR, DATA and WRITE.
- done  out  1  sticky: load completed.
- error  out  1  sticky: header count exceeds MAX_WORDS.
- words_written  out  16  number of records issued in the current load.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: reset==0 at a posedge of clk resets the block. There is no asynchronous path.
  - On reset: state=IDLE, config_addr=IDLE_ADDR, config_data=0, busy=0, done=0, error=0, words_written=0, all shadow registers and byte index = 0.
  - Reset mid-record (in any state) drops the partial record. No config write is emitted, and config_addr shows IDLE_ADDR from the next cycle.
- Handshake:
  - A byte transfers on a posedge where in_valid && in_ready.
  - in_ready is combinational from state only: 1 in COUNT, ADDR and DATA; 0 otherwise. It does not depend on in_valid.
  - in_valid low stalls the FSM indefinitely, with no timeout. in_data is ignored when not transferred.
- Byte packing: all 32-bit fields arrive as 4 bytes, least-significant byte first. A 2-bit byte index counts 0..3 and wraps to 0 on the 4th byte.
- FSM states and transitions:
  - IDLE: start=1 -> COUNT. The same edge clears done, error and words_written.
  - COUNT: assemble the 32-bit count. After the 4th byte:
    - count==0 -> DONE.
    - count>MAX_WORDS -> ERROR.
    - otherwise remaining=count -> ADDR.
  - ADDR: assemble the address shadow. After the 4th byte -> DATA.
  - DATA: assemble the data shadow. On the edge accepting the 4th byte:
    - config_addr <= address shadow.
    - config_data <= {byte3, shadow[23:0]}.
    - -> WRITE.
  - WRITE: lasts exactly 1 cycle; this is the cycle the tile sees the write. On the next edge:
    - config_addr <= IDLE_ADDR and config_data <= 0.
    - words_written increments and remaining decrements.
    - remaining==1 before decrement -> DONE, else -> ADDR.
  - DONE: done=1, held. start=1 -> COUNT, clearing done and words_written.
  - ERROR: error=1, held, and in_ready=0. start=1 -> COUNT, clearing error.
- Outputs:
  - config_addr and config_data are registered. Outside WRITE they are always IDLE_ADDR and 0.
  - There is no back-to-back write: minimum 9 cycles per record (8 transfer cycles + 1 WRITE). Peak rate is 1 write per 9 clk.
- Boundary rules:
  - start is ignored while busy=1.
  - A record whose address equals IDLE_ADDR is still issued for one cycle; it is harmless.
  - words_written wraps modulo 2^16. This is unreachable with the default MAX_WORDS.
  - A count of exactly MAX_WORDS is legal.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with in_valid=1 -> config_addr=32'hFFFF_FFFF, config_data=0, in_ready=0, busy=0, done=0, error=0. Release reset with start=0 -> outputs unchanged for 10 cycles.
- Single record: start, then bytes 01 00 00 00, 05 00 07 00, 03 00 00 00 with in_valid held high -> exactly one cycle where config_addr=32'h0007_0005 and config_data=32'h0000_0003. The next cycle config_addr=IDLE_ADDR, done=1, words_written=1, busy=0.
- Stalls and throughput: 3 records with in_valid toggled randomly -> exactly 3 one-cycle writes with the correct addr/data in order, and no write before its 8th byte. With in_valid always high, writes are 9 cycles apart.
- Count boundaries:
  - count=0 -> done=1 after 4 bytes, no write.
  - count=1024 -> accepted, busy=1.
  - count=1025 -> error=1, in_ready=0. Then start -> error clears and in_ready=1.
- Reset mid-operation: assert reset after the 7th byte of a record -> no config write ever appears. After release and a fresh start, a full record writes normally and words_written=1.
- start while busy: pulse start during ADDR of a 2-record load -> ignored. Both writes are emitted and done=1 at the end.
